// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding
// and per-digit saturation used when a preset is captured.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a nibble to a legal BCD digit; anything above 9 becomes 9.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One stage of the BCD borrow chain: subtracts borrow_in from a digit,
// wrapping 0 to 9 and propagating a borrow to the next digit.
module bcd_digit_dec
    import bcd_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);

    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_next = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with runtime preset, pause/resume, tick
// prescaler, one-cycle expiry pulse and a level done flag.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 25_000_000,
    parameter int DIV_W    = 25
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic [4*DIGITS-1:0] preset,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                tick,
    output logic                expired,
    output logic                done
);

    localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic                tick_q, tick_d;
    logic                expired_q, expired_d;
    logic                running_q, done_q;

    logic [4*DIGITS-1:0] preset_sat;
    logic [4*DIGITS-1:0] bcd_dec;
    logic [DIGITS:0]     borrow;
    logic                bcd_is_zero;
    logic                dec_is_zero;
    logic                presc_term;

    // The chain is always fed a borrow; it ripples out of the top digit
    // only when every digit is 0, which doubles as the zero detector.
    assign borrow[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign preset_sat[4*gi +: 4] = sat_digit(preset[4*gi +: 4]);

        bcd_digit_dec u_dec (
            .digit      (bcd_q[4*gi +: 4]),
            .borrow_in  (borrow[gi]),
            .digit_next (bcd_dec[4*gi +: 4]),
            .borrow_out (borrow[gi+1])
        );
    end

    assign bcd_is_zero = borrow[DIGITS];
    assign dec_is_zero = (bcd_dec == '0);
    assign presc_term  = (presc_q == PRESC_TERM);

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;

        if (load) begin
            bcd_d   = preset_sat;
            presc_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // pause outranks start, so a simultaneous pair does nothing here
                    if (start && !pause) begin
                        if (bcd_is_zero) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (presc_term) begin
                        presc_d = '0;
                        bcd_d   = bcd_dec;
                        tick_d  = 1'b1;
                        if (dec_is_zero) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    bcd_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign bcd     = bcd_q;
    assign running = running_q;
    assign tick    = tick_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised N-digit BCD countdown timer for game and music play sessions. It is the successor to the fixed two-digit, preset-by-mode timer. Adds runtime preset loading, pause/resume, a configurable tick prescaler, an expiry pulse and a done flag. Its digit outputs feed the 7-segment display driver, and `expired` feeds the game/music control FSM.

Parameters:
DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
TICK_DIV, 25_000_000, CLK cycles per count decrement (≥2).
DIV_W, 25, prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
CLK  in  1  system clock.
RST  in  1  asynchronous, active-high reset.
load  in  1  1-cycle pulse: capture `preset`, go to IDLE.
preset  in  4*DIGITS  BCD preset value, digit i at [4i+3:4i].
start  in  1  1-cycle pulse: begin counting, or resume from PAUSE.
pause  in  1  1-cycle pulse: freeze counting.
bcd  out  4*DIGITS  current count, BCD.
running  out  1  high in RUN.
tick  out  1  1-cycle pulse on each decrement.
expired  out  1  1-cycle pulse when the count reaches 0.
done  out  1  level, high in DONE.

Behaviour:
- Reset (async, RST=1):
  - bcd=0, prescaler=0, state=IDLE.
  - running, tick, expired and done are all 0.
- All other logic is synchronous to posedge CLK. All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE.
- Priority per cycle is load > pause > start.
- load (any state):
  - bcd ← sanitised preset; any digit >9 loads as 9.
  - prescaler ← 0, state ← IDLE.
  - Suppresses tick/expired in that cycle.
- IDLE:
  - start with bcd≠0 → RUN, prescaler ← 0.
  - start with bcd=0 → DONE, with expired=1 for exactly the next cycle.
  - pause is ignored.
- RUN:
  - Prescaler increments each cycle.
  - At prescaler=TICK_DIV-1: prescaler ← 0, bcd decrements by 1, tick=1 for the following cycle.
  - Decrement is a BCD borrow chain: a digit at 0 wraps to 9 and borrows from the next digit.
  - If the decremented value is 0: state ← DONE, expired=1 concurrently with that tick.
  - pause → PAUSE; the prescaler holds its value; a pause in the same cycle as the terminal count wins, so no decrement happens.
  - start is ignored.
- PAUSE:
  - bcd and prescaler frozen.
  - start → RUN, continuing from the held prescaler value (no lost partial interval).
- DONE:
  - bcd holds 0, done=1.
  - start and pause are ignored; only load or RST leaves DONE.
- Decrement interval is exactly TICK_DIV cycles in RUN. The first tick arrives TICK_DIV cycles after the start pulse.
- Count never underflows; 0 is terminal.
- running = (state==RUN); done = (state==DONE).
- Reset asserted mid-run clears immediately and asynchronously. Counting resumes only after a load+start.

Decomposition:
- Package bcd_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - constant BCD_MAX=4'd9.
  - function for saturating a digit.
- Sub-module bcd_digit_dec: a single combinational digit.
  - Inputs: digit, borrow_in. Outputs: next digit, borrow_out.
  - Instantiated DIGITS times in a generate loop.

Test Plan:
1. DIGITS=2, TICK_DIV=4; load 0x12, start → tick every 4 cycles; bcd sequence 12,11,10,09,…,01,00. expired pulses once, coincident with 00; done=1 after; 48 cycles start→expired.
2. Load 0x3F → bcd=0x39. Load 0xA0 → bcd=0x90. No tick or expired during either load.
3. Load 0x05, start, pause at prescaler=2 for 10 cycles, start → next tick arrives 2 cycles after resume; bcd 04; running low during pause.
4. Load 0x00, start → done=1 and expired pulses 1 cycle; bcd stays 00; later start/pause have no effect.
5. Mid-RUN at bcd=0x07: load 0x20 coincident with a terminal count → bcd=0x20, IDLE, no tick. Then RST asynchronously pulsed → all outputs 0 before the next CLK edge.
6. DIGITS=3, load 0x100 → first tick gives 0x099 (borrow across two digits); pause and start asserted together → PAUSE.
